// File: rtl/step_counter_pkg.sv
// -----------------------------------------------------------------------------
// step_counter_pkg
// Shared constants for the step counter and its add/subtract datapath.
//   DEFAULT_WIDTH : default counter/data width in bits
//   MODE_WRAP     : SATURATE encoding for modulo 2^WIDTH wrap-around
//   MODE_SAT      : SATURATE encoding for clamping at the range limits
// -----------------------------------------------------------------------------
package step_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : step_counter_pkg

// File: rtl/step_counter_incdec_step.sv
// -----------------------------------------------------------------------------
// incdec_step
// Purely combinational add/subtract stage used by step_counter.
// Ports:
//   a   [WIDTH-1:0] in  : current value
//   b   [WIDTH-1:0] in  : unsigned step magnitude
//   up              in  : 1 = a + b, 0 = a - b
//   sum [WIDTH-1:0] out : low WIDTH bits of the result
//   cb              out : carry (up) or borrow (down) from bit WIDTH
// -----------------------------------------------------------------------------
module incdec_step
  import step_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             up,
  output logic [WIDTH-1:0] sum,
  output logic             cb
);

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic [WIDTH:0] w_result;

  assign w_a_ext = {1'b0, a};
  assign w_b_ext = {1'b0, b};

  // On subtraction the extended result underflows into bit WIDTH exactly
  // when b > a, so the same top bit serves as carry or borrow.
  assign w_result = up ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);

  assign sum = w_result[WIDTH-1:0];
  assign cb  = w_result[WIDTH];

endmodule : incdec_step

// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
// Up/down counter that moves by a programmable step, with parallel load,
// optional saturation, a carry/borrow pulse and a sticky overflow flag.
// Update priority on each rising clk edge: reset > load > count > hold.
// Ports:
//   clk               in  : clock, all state changes on rising edge
//   rst_n             in  : synchronous active-low reset
//   en                in  : count enable
//   up                in  : 1 = add step, 0 = subtract step
//   step  [WIDTH-1:0] in  : unsigned step magnitude
//   ld                in  : parallel load strobe
//   d     [WIDTH-1:0] in  : parallel load value
//   clr_ovf           in  : clear sticky overflow
//   q     [WIDTH-1:0] out : registered count
//   co                out : registered one-cycle carry/borrow pulse
//   tc                out : combinational terminal count for current direction
//   ovf               out : registered sticky overflow
// -----------------------------------------------------------------------------
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic             w_cb;
  logic [WIDTH-1:0] w_next_q;
  logic             w_count;
  logic             w_carry_evt;

  incdec_step #(
    .WIDTH (WIDTH)
  ) u_incdec_step (
    .a   (r_q),
    .b   (step),
    .up  (up),
    .sum (w_sum),
    .cb  (w_cb)
  );

  // Counting only happens when not overridden by a load.
  assign w_count     = en & ~ld;
  assign w_carry_evt = w_count & w_cb;

  always_comb begin
    // NOTE: default assignment first so every path drives w_next_q and no
    // latch is inferred.
    w_next_q = w_sum;
    if ((SATURATE == MODE_SAT) && w_cb) begin
      // A carry can only occur counting up and a borrow only counting down,
      // so direction alone picks the limit to clamp to.
      w_next_q = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (ld) begin
        r_q  <= d;
        r_co <= 1'b0;
      end else if (en) begin
        r_q  <= w_next_q;
        r_co <= w_cb;
      end else begin
        r_co <= 1'b0;
      end

      // A new carry/borrow takes precedence over a clear on the same edge.
      if (w_carry_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign co  = r_co;
  assign ovf = r_ovf;

  // Terminal count looks at the limit in the currently selected direction.
  assign tc = up ? (&r_q) : ~(|r_q);

endmodule : step_counter
